// File: rtl/reset_release_sequencer_pkg.sv
// Shared definitions for the reset release sequencer: FSM encoding, default
// parameter values and a width helper.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_SYNC   = 3'd1,
    S_HOLD_R = 3'd2,
    S_REL    = 3'd3,
    S_IDLE   = 3'd4,
    S_HOLD_S = 3'd5
  } state_t;

  localparam int DEF_NGRP        = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_HOLD_CYC    = 4;
  localparam int DEF_GAP_CYC     = 2;
  localparam int DEF_CNTW        = 8;

  // Group index width; a single group still needs one bit.
  function automatic int gidx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_release_sequencer_if.sv
// Request/status bundle between software control and the reset sequencer.
interface reset_release_sequencer_if
  import rst_seq_pkg::*;
#(
  parameter int NGRP = DEF_NGRP
);

  logic            REQ_RST;
  logic            REQ_SET;
  logic [NGRP-1:0] RSTB;
  logic [NGRP-1:0] SETB;
  logic            BUSY;
  logic            DONE;

  // Requester side: raises timed pulse requests and watches status.
  modport master (
    output REQ_RST, REQ_SET,
    input  RSTB, SETB, BUSY, DONE
  );

  // Sequencer side: samples requests and drives the flop-group pins.
  modport slave (
    input  REQ_RST, REQ_SET,
    output RSTB, SETB, BUSY, DONE
  );

endinterface

// File: rtl/reset_release_sequencer_sync.sv
// Reset-release synchronizer: a 1 shifts in after RST falls; RST clears the
// whole chain asynchronously, so even a short glitch restarts the release.
module rst_sync_chain
  import rst_seq_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic CLK,
  input  logic RST,
  output logic sync_n
);

  logic [STAGES-1:0] chain;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, giving a true shift.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], 1'b1};
    end
  end

  assign sync_n = chain[STAGES-1];

endmodule

// File: rtl/reset_release_sequencer.sv
// Async-assert / sync-release sequencer driving the active-low RSTB/SETB pins
// of NGRP flop groups, with staggered release and timed software pulses.
module reset_release_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NGRP        = DEF_NGRP,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int HOLD_CYC    = DEF_HOLD_CYC,
  parameter int GAP_CYC     = DEF_GAP_CYC,
  parameter int CNTW        = DEF_CNTW
) (
  input  logic                        CLK,
  input  logic                        RST,
  reset_release_sequencer_if.slave    bus
);

  localparam int GW = gidx_width(NGRP);

  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(HOLD_CYC - 1);
  localparam logic [CNTW-1:0] GAP_LAST  = CNTW'(GAP_CYC - 1);
  localparam logic [GW-1:0]   GIDX_LAST = GW'(NGRP - 1);

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [GW-1:0]   gidx;
  logic [NGRP-1:0] rstb_q;
  logic [NGRP-1:0] setb_q;
  logic            busy_q;
  logic            done_q;
  logic            sync_n;

  rst_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .CLK    (CLK),
    .RST    (RST),
    .sync_n (sync_n)
  );

  // Counter saturates at all-ones instead of wrapping.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // NOTE: RST reaches the pins asynchronously through the flop reset, so
  // assertion needs no clock; release only ever happens on a CLK edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_RESET;
      cnt    <= '0;
      gidx   <= '0;
      rstb_q <= '0;
      setb_q <= '1;
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_RESET: begin
          state <= S_SYNC;
        end

        S_SYNC: begin
          if (sync_n) begin
            cnt   <= '0;
            state <= S_HOLD_R;
          end
        end

        S_HOLD_R: begin
          if (cnt == HOLD_LAST) begin
            rstb_q[0] <= 1'b1;
            gidx      <= '0;
            cnt       <= '0;
            state     <= S_REL;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        // Last group was released on the previous edge: finish one edge later.
        S_REL: begin
          if (gidx == GIDX_LAST) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= S_IDLE;
          end else if (cnt == GAP_LAST) begin
            rstb_q[gidx + 1'b1] <= 1'b1;
            gidx                <= gidx + 1'b1;
            cnt                 <= '0;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        // Reset request has priority; the set request is simply dropped.
        S_IDLE: begin
          if (bus.REQ_RST) begin
            rstb_q <= '0;
            busy_q <= 1'b1;
            cnt    <= '0;
            state  <= S_HOLD_R;
          end else if (bus.REQ_SET) begin
            setb_q <= '0;
            busy_q <= 1'b1;
            cnt    <= '0;
            state  <= S_HOLD_S;
          end
        end

        S_HOLD_S: begin
          if (&setb_q) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= S_IDLE;
          end else if (cnt == HOLD_LAST) begin
            setb_q <= '1;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        default: begin
          state <= S_RESET;
        end
      endcase
    end
  end

  assign bus.RSTB = rstb_q;
  assign bus.SETB = setb_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;

endmodule
